// File: rtl/alu_pkg.sv
// Shared types and constants for the alu16 command sequencer.
package alu_pkg;

  // Default datapath widths of alu16
  localparam int ALU_W   = 16;
  localparam int ALU_OPW = 3;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // alu16 opcode map
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer for alu16: accepts one request, holds the operands on the
// ALU inputs, pulses alu_on, waits a fixed latency, captures the result and
// offers it downstream. One operation in flight at a time.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W         = ALU_W,
  parameter int OPW       = ALU_OPW,
  parameter int ON_CYCLES = 1,
  parameter int LATENCY   = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic [OPW-1:0] req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W:0]     rsp_data,
  output logic [OPW-1:0] rsp_op,
  output logic           alu_on,
  output logic [W-1:0]   alu_ina,
  output logic [W-1:0]   alu_inb,
  output logic [OPW-1:0] alu_op,
  input  logic [W:0]     alu_out,
  input  logic [3:0]     alu_count,
  output logic           busy
);

  // Terminal counts; counters start at 0 on state entry so the last value is N-1
  localparam logic [3:0] ON_LAST  = 4'(ON_CYCLES - 1);
  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] on_cnt;
  logic [7:0] lat_cnt;
  logic       accept;
  logic       on_done;
  logic       lat_done;

  // alu_count is a status tap from alu16; sequencing relies on fixed timing only
  logic unused_count;
  assign unused_count = ^alu_count;

  // State register; reset aborts any operation and drops alu_on at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus state-decoded handshake and ALU control outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_on    = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    on_done   = 1'b0;
    lat_done  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        accept    = req_valid;
        if (req_valid) state_nxt = START;
      end
      START: begin
        alu_on  = 1'b1;
        on_done = (on_cnt == ON_LAST);
        if (on_done) state_nxt = WAIT;
      end
      WAIT: begin
        lat_done = (lat_cnt == LAT_LAST);
        if (lat_done) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // on_cnt/lat_cnt clear on entry to START/WAIT and stop at their terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_cnt  <= '0;
      lat_cnt <= '0;
    end else begin
      if (accept) begin
        on_cnt <= '0;
      end else if (state == START && !on_done) begin
        on_cnt <= on_cnt + 4'd1;
      end
      if (on_done) begin
        lat_cnt <= '0;
      end else if (state == WAIT && !lat_done) begin
        lat_cnt <= lat_cnt + 8'd1;
      end
    end
  end

  // Operands load only on acceptance; result and opcode load on the last WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ina  <= '0;
      alu_inb  <= '0;
      alu_op   <= '0;
      rsp_data <= '0;
      rsp_op   <= '0;
    end else begin
      if (accept) begin
        alu_ina <= req_a;
        alu_inb <= req_b;
        alu_op  <= req_op;
      end
      if (lat_done) begin
        rsp_data <= alu_out;
        rsp_op   <= alu_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed requests with hand-computed
// results, an alu16 behavioural stub per instance, and a response monitor
// that pops expected results on every downstream handshake.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int LAT1 = 17;
  localparam int LAT2 = 2;
  localparam logic [16:0] JUNK = 17'h15A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic        req_valid1 = 1'b0, req_ready1, rsp_valid1, rsp_ready1 = 1'b0;
  logic [15:0] req_a1 = '0, req_b1 = '0, alu_ina1, alu_inb1;
  logic [2:0]  req_op1 = '0, rsp_op1, alu_op1;
  logic [16:0] rsp_data1, alu_out1;
  logic        alu_on1, busy1;
  logic [3:0]  alu_count1;

  // Instance 2: ON_CYCLES=3, LATENCY=2
  logic        req_valid2 = 1'b0, req_ready2, rsp_valid2, rsp_ready2 = 1'b0;
  logic [15:0] req_a2 = '0, req_b2 = '0, alu_ina2, alu_inb2;
  logic [2:0]  req_op2 = '0, rsp_op2, alu_op2;
  logic [16:0] rsp_data2, alu_out2;
  logic        alu_on2, busy2;
  logic [3:0]  alu_count2;

  alu_sequencer u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_op(req_op1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_op(rsp_op1),
    .alu_on(alu_on1), .alu_ina(alu_ina1), .alu_inb(alu_inb1), .alu_op(alu_op1),
    .alu_out(alu_out1), .alu_count(alu_count1), .busy(busy1)
  );

  alu_sequencer #(.ON_CYCLES(3), .LATENCY(LAT2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .req_op(req_op2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_data(rsp_data2), .rsp_op(rsp_op2),
    .alu_on(alu_on2), .alu_ina(alu_ina2), .alu_inb(alu_inb2), .alu_op(alu_op2),
    .alu_out(alu_out2), .alu_count(alu_count2), .busy(busy2)
  );

  typedef struct packed {
    logic [16:0] data;
    logic [2:0]  op;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  exp_t e1, e2;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // alu16 stubs: garbage on alu_out until the last WAIT cycle, then the result
  int   wc1 = 0, wc2 = 0;
  logic on1_q = 1'b0, on2_q = 1'b0;
  assign alu_count1 = wc1[3:0];
  assign alu_count2 = wc2[3:0];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      on1_q <= 1'b0; wc1 <= 0; alu_out1 <= JUNK;
    end else begin
      on1_q <= alu_on1;
      if (on1_q && !alu_on1) wc1 <= 1;
      else if (wc1 != 0 && wc1 < LAT1) wc1 <= wc1 + 1;
      if (alu_on1) alu_out1 <= JUNK;
      else if (wc1 == LAT1 - 1) alu_out1 <= alu_model(alu_ina1, alu_inb1, alu_op1);
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      on2_q <= 1'b0; wc2 <= 0; alu_out2 <= JUNK;
    end else begin
      on2_q <= alu_on2;
      if (on2_q && !alu_on2) wc2 <= 1;
      else if (wc2 != 0 && wc2 < LAT2) wc2 <= wc2 + 1;
      if (alu_on2) alu_out2 <= JUNK;
      else if (wc2 == LAT2 - 1) alu_out2 <= alu_model(alu_ina2, alu_inb2, alu_op2);
    end
  end

  // Response monitors: every downstream handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid1 && rsp_ready1) begin
      if (sb1.size() == 0) begin
        check("dut1_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e1 = sb1.pop_front();
        check("dut1_rsp_data", 32'(rsp_data1), 32'(e1.data));
        check("dut1_rsp_op", 32'(rsp_op1), 32'(e1.op));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid2 && rsp_ready2) begin
      if (sb2.size() == 0) begin
        check("dut2_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e2 = sb2.pop_front();
        check("dut2_rsp_data", 32'(rsp_data2), 32'(e2.data));
        check("dut2_rsp_op", 32'(rsp_op2), 32'(e2.op));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int waited = 0;
    while (!req_ready1 && waited < 200) begin
      tick();
      waited++;
    end
    if (!req_ready1) check($sformatf("%s_accept_timeout", tag), 32'd0, 32'd1);
    tick();
  endtask

  // One operation on instance 1, from request to post-handshake IDLE cycle
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [16:0] exp_d,
                        input bit pre_ready, input int stall, input bit scramble,
                        input bit hold_next, input logic [15:0] na, input logic [15:0] nb);
    int k, first_v, on_n;
    bit stable, rdy_low, hold_ok, done;
    rsp_ready1 = pre_ready;
    req_a1 = a; req_b1 = b; req_op1 = op; req_valid1 = 1'b1;
    wait_accept(tag);
    sb1.push_back('{data: exp_d, op: op});
    if (hold_next) begin
      req_a1 = na; req_b1 = nb;
    end else begin
      req_valid1 = 1'b0;
    end
    k = 1; first_v = -1; on_n = 0;
    stable = 1'b1; rdy_low = 1'b1; hold_ok = 1'b1; done = 1'b0;
    while (!done && k < 100) begin
      if (scramble) begin
        req_a1 = 16'($urandom);
        req_b1 = 16'($urandom);
      end
      if (alu_ina1 !== a || alu_inb1 !== b || alu_op1 !== op) stable = 1'b0;
      if (req_ready1 !== 1'b0 || busy1 !== 1'b1) rdy_low = 1'b0;
      if (alu_on1) on_n++;
      if (rsp_valid1 && first_v < 0) first_v = k;
      if (rsp_valid1 && (rsp_data1 !== exp_d || rsp_op1 !== op)) hold_ok = 1'b0;
      if (first_v >= 0 && k >= first_v + stall) rsp_ready1 = 1'b1;
      if (rsp_valid1 && rsp_ready1) done = 1'b1;
      tick();
      k++;
    end
    rsp_ready1 = 1'b0;
    check($sformatf("%s_done", tag), 32'(done), 32'd1);
    check($sformatf("%s_rsp_latency", tag), 32'(first_v), 32'd19);
    check($sformatf("%s_on_cycles", tag), 32'(on_n), 32'd1);
    check($sformatf("%s_operands_stable", tag), 32'(stable), 32'd1);
    check($sformatf("%s_ready_low_busy", tag), 32'(rdy_low), 32'd1);
    check($sformatf("%s_rsp_held", tag), 32'(hold_ok), 32'd1);
    check($sformatf("%s_valid_drop", tag), 32'(rsp_valid1), 32'd0);
    check($sformatf("%s_ready_back", tag), 32'(req_ready1), 32'd1);
    check($sformatf("%s_idle", tag), 32'(busy1), 32'd0);
    check($sformatf("%s_ina_kept", tag), 32'(alu_ina1), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, first_v, on_n;
    // Reset state
    repeat (5) tick();
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_alu_on", 32'(alu_on1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_rsp_data", 32'(rsp_data1), 32'd0);
    check("rst_alu_ina", 32'(alu_ina1), 32'd0);
    check("rst_req_ready", 32'(req_ready1), 32'd1);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_alu_on", 32'(alu_on1), 32'd0);
    check("idle_busy", 32'(busy1), 32'd0);

    // Basic add, then carry-out with rsp_ready held high in advance
    run_op("t1_add", 16'h001F, 16'h001F, OP_ADD, 17'h0003E, 1'b0, 2, 1'b0, 1'b0, '0, '0);
    run_op("t2_carry", 16'hFFFF, 16'h0001, OP_ADD, 17'h10000, 1'b1, 0, 1'b0, 1'b0, '0, '0);

    // Back-pressure: second request waits while the first result stalls 10 cycles
    run_op("t3_first", 16'h0010, 16'h0020, OP_ADD, 17'h00030, 1'b0, 10, 1'b0, 1'b1,
           16'h0002, 16'h0003);
    run_op("t3_second", 16'h0002, 16'h0003, OP_ADD, 17'h00005, 1'b0, 0, 1'b0, 1'b0, '0, '0);

    // Request lines toggling during the operation
    run_op("t4_sub", 16'h0005, 16'h0003, OP_SUB, 17'h00002, 1'b0, 3, 1'b1, 1'b0, '0, '0);
    run_op("t4_xor", 16'h00FF, 16'h0F0F, OP_XOR, 17'h00FF0, 1'b1, 0, 1'b1, 1'b0, '0, '0);

    // Reset during WAIT at lat_cnt == 8, then a fresh operation
    req_a1 = 16'h1234; req_b1 = 16'h0001; req_op1 = OP_ADD; req_valid1 = 1'b1;
    wait_accept("t5");
    req_valid1 = 1'b0;
    repeat (9) tick();
    check("t5_busy_before_rst", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_alu_on", 32'(alu_on1), 32'd0);
    check("t5_rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("t5_rst_busy", 32'(busy1), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_op("t5_after", 16'h0007, 16'h0009, OP_ADD, 17'h00010, 1'b0, 1, 1'b0, 1'b0, '0, '0);

    // Instance with ON_CYCLES=3, LATENCY=2
    rsp_ready2 = 1'b1;
    req_a2 = 16'h0100; req_b2 = 16'h0100; req_op2 = OP_ADD; req_valid2 = 1'b1;
    check("t6_req_ready", 32'(req_ready2), 32'd1);
    tick();
    sb2.push_back('{data: 17'h00200, op: OP_ADD});
    req_valid2 = 1'b0;
    first_v = -1; on_n = 0;
    for (k = 1; k < 30 && first_v < 0; k++) begin
      if (alu_on2) on_n++;
      if (rsp_valid2) first_v = k;
      tick();
    end
    check("t6_on_cycles", 32'(on_n), 32'd3);
    check("t6_rsp_latency", 32'(first_v), 32'd6);
    check("t6_valid_drop", 32'(rsp_valid2), 32'd0);
    rsp_ready2 = 1'b0;

    repeat (3) tick();
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    check("sb2_drained", 32'(sb2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
